gate_scheduler: RTL and testbench
=================================

# gate_scheduler

Scheduler for the single shared barrier lane between the entry and exit sensors of the parking lot. It latches entry and exit requests, grants the lane to one direction at a time with fair alternation, refuses entry while the lot is full, and opens the barrier until the direction FSM reports a completed passage or a timeout expires. It sits between the request inputs (debounced and pulse-detected) and the in/out FSM plus 3-bit occupancy counter, whose `in`/`out` pulses and `count` it consumes.

## Interface
- `OPEN_TICKS`, default 240000: maximum cycles barrier stays open per grant (≥2).
- `CLOSE_TICKS`, default 48000: guard cycles barrier stays closed after each service (≥1).
- `CAPACITY`, default 7: occupancy at which entry is refused (≤7).
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `req_in`  in  1  one-cycle entry request pulse.
- `req_out`  in  1  one-cycle exit request pulse.
- `car_in`  in  1  one-cycle "car fully entered" pulse from direction FSM.
- `car_out`  in  1  one-cycle "car fully exited" pulse from direction FSM.
- `count`  in  3  current occupancy.
- `gate_open`  out  1  barrier open command.
- `dir`  out  1  lane direction while open: 1 entry, 0 exit.
- `grant_in` / `grant_out`  out  1  one-cycle pulse on first cycle of a grant.
- `full`  out  1  combinational `count >= CAPACITY`.
- `timeout`  out  1  one-cycle pulse when a grant ends without passage.
- `dir_err`  out  1  one-cycle pulse on completion pulse of wrong direction while open.

## Operation
- States: IDLE, OPEN_IN, OPEN_OUT, GUARD. Reset → IDLE, `pend_in=pend_out=0`, `last_served=0` (exit), timer 0, all outputs 0 except `full` (follows `count`).
- Pending flags: `req_x` sets `pend_x`; grant of x clears it; set and clear in the same cycle → set wins (queued next car). Requests accepted in every state.
- IDLE arbitration: eligible_in = `pend_in && !full`; eligible_out = `pend_out`. One eligible → grant it. Both → grant the direction opposite `last_served`. None → stay. `pend_in` while full stays pending, not dropped.
- Grant: go to OPEN_x, pulse `grant_x`, load timer `OPEN_TICKS-1`, update `last_served`.
- OPEN_IN: `car_in` → GUARD. `car_out` → `dir_err` pulse, stay. Timer 0 without `car_in` → GUARD, `timeout` pulse. `car_in` on timer-0 cycle counts as passage, no timeout. OPEN_OUT symmetric.
- GUARD: load timer `CLOSE_TICKS-1` on entry; at 0 → IDLE.
- `gate_open` = state is OPEN_IN/OPEN_OUT (registered state decode). `dir` = 1 in OPEN_IN, else 0.
- Asynchronous reset mid-grant: barrier closes immediately, pending requests lost.

## Timing
- `req_x` at cycle t → `pend_x` visible t+1 → `gate_open`, `grant_x` high t+2 (from IDLE, eligible).
- Timeout: `gate_open` high exactly `OPEN_TICKS` cycles.
- Passage at cycle p in OPEN → `gate_open` low from p+1.
- GUARD lasts `CLOSE_TICKS` cycles; then ≥1 IDLE cycle; minimum closed gap between grants `CLOSE_TICKS+1`.
- `full` re-evaluated every cycle; entry eligibility sampled only in IDLE.
- Timer width `$clog2(max(OPEN_TICKS,CLOSE_TICKS))`, saturates at 0.

## Structure
- Package `parking_pkg`: state enum `gate_state_t`, direction constants `DIR_IN=1`/`DIR_OUT=0`, default tick constants.
- One sub-module `tick_timer` (load value, load strobe, down-count, `zero` flag); FSM, pending flags and arbitration in `gate_scheduler`.

## Test plan
Use OPEN_TICKS=8, CLOSE_TICKS=2, CAPACITY=7.
- Reset release, `req_in` at t=5, `car_in` at t=10 → `grant_in`/`gate_open`/`dir=1` at t=7, `gate_open` low t=11, IDLE at t=13.
- `req_in` and `req_out` same cycle, `last_served=0` → entry first; exit granted 3 cycles after entry passage; then repeat pair → exit served first? no: alternation gives entry again (last_served=out).
- `count=7`, `req_in` then `req_out` → only exit granted; after `count` drops to 6 and GUARD ends, pending entry granted.
- `req_out`, no passage → `gate_open` high 8 cycles, `timeout` pulse on last, IDLE after 2 guard cycles.
- In OPEN_IN inject `car_out` → `dir_err` pulse, gate stays open; new `req_in` during OPEN_IN → re-granted after guard.
- Assert `reset` low mid-OPEN_OUT with `pend_in` set → `gate_open`, flags cleared immediately; no grant after release.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking-lot barrier scheduler.
// Provides the gate FSM state enum, lane direction encodings, default
// tick counts and a helper that sizes the shared open/guard timer.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OPEN_IN  = 2'd1,
    OPEN_OUT = 2'd2,
    GUARD    = 2'd3
  } gate_state_t;

  localparam logic DIR_IN  = 1'b1;
  localparam logic DIR_OUT = 1'b0;

  localparam int unsigned DEF_OPEN_TICKS  = 240000;
  localparam int unsigned DEF_CLOSE_TICKS = 48000;
  localparam int unsigned DEF_CAPACITY    = 7;

  // Bits needed to hold max(a, b) - 1, never less than one.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter that saturates at zero.
// Ports: clk, reset (async active-low), load (strobe), load_val (value to
// load), zero (counter currently at zero).
module tick_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;

  // Load takes priority; otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/gate_scheduler.sv
// Shared barrier-lane scheduler for the parking lot.
// Latches entry/exit requests, grants the lane to one direction at a time
// with alternation on contention, refuses entry while full, and holds the
// barrier open until a passage is reported or the open timer expires,
// followed by a closed guard interval.
// Ports:
//   clk, reset (async active-low)
//   req_in / req_out   : one-cycle request pulses
//   car_in / car_out   : one-cycle passage-complete pulses
//   count              : current occupancy
//   gate_open, dir     : barrier command and lane direction (1 = entry)
//   grant_in/grant_out : pulse on the first open cycle of a grant
//   full               : count >= CAPACITY (combinational)
//   timeout            : pulse on the last open cycle when no passage
//   dir_err            : pulse on a wrong-direction passage while open
module gate_scheduler
  import parking_pkg::*;
#(
  parameter int unsigned OPEN_TICKS  = DEF_OPEN_TICKS,
  parameter int unsigned CLOSE_TICKS = DEF_CLOSE_TICKS,
  parameter int unsigned CAPACITY    = DEF_CAPACITY
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_in,
  input  logic       req_out,
  input  logic       car_in,
  input  logic       car_out,
  input  logic [2:0] count,
  output logic       gate_open,
  output logic       dir,
  output logic       grant_in,
  output logic       grant_out,
  output logic       full,
  output logic       timeout,
  output logic       dir_err
);

  localparam int unsigned TW = timer_width(OPEN_TICKS, CLOSE_TICKS);
  localparam logic [TW-1:0] OPEN_LOAD  = TW'(OPEN_TICKS - 1);
  localparam logic [TW-1:0] CLOSE_LOAD = TW'(CLOSE_TICKS - 1);

  gate_state_t   state_q, state_d;
  logic          pend_in_q, pend_out_q;
  logic          last_served_q;
  logic          grant_in_q, grant_out_q;
  logic          take_in, take_out;
  logic          elig_in, elig_out;
  logic          timer_load;
  logic [TW-1:0] timer_val;
  logic          timer_zero;

  tick_timer #(.WIDTH(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  assign full     = (count >= 3'(CAPACITY));
  assign elig_in  = pend_in_q && !full;
  assign elig_out = pend_out_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, arbitration and timer loading.
  always_comb begin
    state_d    = state_q;
    take_in    = 1'b0;
    take_out   = 1'b0;
    timer_load = 1'b0;
    timer_val  = OPEN_LOAD;
    unique case (state_q)
      IDLE: begin
        // On contention, serve the direction not served last.
        if (elig_in && (!elig_out || last_served_q == DIR_OUT)) begin
          take_in    = 1'b1;
          state_d    = OPEN_IN;
          timer_load = 1'b1;
        end else if (elig_out) begin
          take_out   = 1'b1;
          state_d    = OPEN_OUT;
          timer_load = 1'b1;
        end
      end
      OPEN_IN: begin
        if (car_in || timer_zero) begin
          state_d    = GUARD;
          timer_load = 1'b1;
          timer_val  = CLOSE_LOAD;
        end
      end
      OPEN_OUT: begin
        if (car_out || timer_zero) begin
          state_d    = GUARD;
          timer_load = 1'b1;
          timer_val  = CLOSE_LOAD;
        end
      end
      GUARD: begin
        if (timer_zero) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the state register; timeout/dir_err coincide with
  // the cycle that causes them.
  always_comb begin
    gate_open = 1'b0;
    dir       = 1'b0;
    timeout   = 1'b0;
    dir_err   = 1'b0;
    unique case (state_q)
      OPEN_IN: begin
        gate_open = 1'b1;
        dir       = 1'b1;
        timeout   = timer_zero && !car_in;
        dir_err   = car_out;
      end
      OPEN_OUT: begin
        gate_open = 1'b1;
        timeout   = timer_zero && !car_out;
        dir_err   = car_in;
      end
      default: ;
    endcase
  end

  // Pending flags (a new request beats the grant clear), grant pulses and
  // fairness history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_in_q     <= 1'b0;
      pend_out_q    <= 1'b0;
      last_served_q <= DIR_OUT;
      grant_in_q    <= 1'b0;
      grant_out_q   <= 1'b0;
    end else begin
      pend_in_q   <= req_in  || (pend_in_q  && !take_in);
      pend_out_q  <= req_out || (pend_out_q && !take_out);
      grant_in_q  <= take_in;
      grant_out_q <= take_out;
      if (take_in) begin
        last_served_q <= DIR_IN;
      end else if (take_out) begin
        last_served_q <= DIR_OUT;
      end
    end
  end

  assign grant_in  = grant_in_q;
  assign grant_out = grant_out_q;

endmodule

// File: tb/tb_gate_scheduler.sv
// Self-checking bench for gate_scheduler: a hand-derived vector table, a
// set of multi-cycle corner sequences, and a randomized run, all checked
// against expectations computed in the bench.
module tb_gate_scheduler;

  localparam int unsigned OPEN  = 8;
  localparam int unsigned CLOSE = 2;
  localparam int unsigned CAP   = 7;
  localparam int          NTBL  = 27;

  logic       clk;
  logic       reset;
  logic       req_in, req_out, car_in, car_out;
  logic [2:0] count;
  logic       gate_open, dir, grant_in, grant_out, full, timeout, dir_err;

  gate_scheduler #(
    .OPEN_TICKS  (OPEN),
    .CLOSE_TICKS (CLOSE),
    .CAPACITY    (CAP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_in    (req_in),
    .req_out   (req_out),
    .car_in    (car_in),
    .car_out   (car_out),
    .count     (count),
    .gate_open (gate_open),
    .dir       (dir),
    .grant_in  (grant_in),
    .grant_out (grant_out),
    .full      (full),
    .timeout   (timeout),
    .dir_err   (dir_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector order: {gate_open, dir, grant_in, grant_out, full, timeout, dir_err}
  typedef struct packed {
    logic       ri;
    logic       ro;
    logic       ci;
    logic       co;
    logic [2:0] cnt;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl [NTBL];

  int n_vec = 0;
  int n_err = 0;
  logic [6:0] last_got;

  // Reference model: time remaining in the current open window or guard
  // interval, plus request bookkeeping.
  int m_open_left;
  int m_guard_left;
  bit m_dir_in;
  bit m_first;
  bit m_pin, m_pout;
  bit m_last_in;

  function automatic logic [6:0] outs_now();
    return {gate_open, dir, grant_in, grant_out, full, timeout, dir_err};
  endfunction

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %b, expected %b", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_open_left  = 0;
    m_guard_left = 0;
    m_dir_in     = 1'b0;
    m_first      = 1'b0;
    m_pin        = 1'b0;
    m_pout       = 1'b0;
    m_last_in    = 1'b0;
  endtask

  function automatic logic [6:0] model_out(input bit ci, input bit co, input logic [2:0] cnt);
    bit op, passed, wrong;
    op     = (m_open_left > 0);
    passed = m_dir_in ? ci : co;
    wrong  = m_dir_in ? co : ci;
    return {op, op && m_dir_in, op && m_first && m_dir_in, op && m_first && !m_dir_in,
            (cnt >= 3'(CAP)), op && (m_open_left == 1) && !passed, op && wrong};
  endfunction

  task automatic model_step(input bit ri, input bit ro, input bit ci, input bit co,
                            input logic [2:0] cnt);
    bit gi, go, ei, eo, passed;
    gi = 1'b0;
    go = 1'b0;
    if (m_open_left > 0) begin
      passed  = m_dir_in ? ci : co;
      m_first = 1'b0;
      if (passed || m_open_left == 1) begin
        m_open_left  = 0;
        m_guard_left = CLOSE;
      end else begin
        m_open_left--;
      end
    end else if (m_guard_left > 0) begin
      m_guard_left--;
    end else begin
      ei = m_pin && (cnt < 3'(CAP));
      eo = m_pout;
      if (ei && (!eo || !m_last_in)) gi = 1'b1;
      else if (eo) go = 1'b1;
      if (gi || go) begin
        m_open_left = OPEN;
        m_dir_in    = gi;
        m_first     = 1'b1;
        m_last_in   = gi;
      end
    end
    m_pin  = ri || (m_pin && !gi);
    m_pout = ro || (m_pout && !go);
  endtask

  // One clock cycle: drive at the falling edge, compare to the model, advance it.
  task automatic cyc(input bit ri, input bit ro, input bit ci, input bit co,
                     input logic [2:0] cnt);
    @(negedge clk);
    req_in  = ri;
    req_out = ro;
    car_in  = ci;
    car_out = co;
    count   = cnt;
    #1;
    last_got = outs_now();
    check("model", last_got, model_out(ci, co, cnt));
    model_step(ri, ro, ci, co, cnt);
  endtask

  task automatic idle(input int n, input logic [2:0] cnt);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset   = 1'b0;
    req_in  = 1'b0;
    req_out = 1'b0;
    car_in  = 1'b0;
    car_out = 1'b0;
    count   = 3'd0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    logic [2:0] rc;
    bit         any_grant;

    reset   = 1'b0;
    req_in  = 1'b0;
    req_out = 1'b0;
    car_in  = 1'b0;
    car_out = 1'b0;
    count   = 3'd0;
    model_reset();

    // Reset state, including full tracking count while held in reset.
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", outs_now(), 7'b0000000);
    count = 3'd7;
    #1;
    check("reset_full", outs_now(), 7'b0000100);
    count = 3'd0;

    // Vector table: entry pass, then exit timeout with a stray car_in.
    for (int i = 0; i < NTBL; i++) tbl[i] = '0;
    tbl[2].cnt = 3'd7; tbl[2].exp = 7'b0000100;
    tbl[3].cnt = 3'd6;
    tbl[5].ri  = 1'b1;
    for (int i = 7; i <= 10; i++) tbl[i].exp = 7'b1100000;
    tbl[7].exp = 7'b1110000;
    tbl[10].ci = 1'b1;
    tbl[14].ro = 1'b1;
    for (int i = 16; i <= 23; i++) tbl[i].exp = 7'b1000000;
    tbl[16].exp = 7'b1001000;
    tbl[18].ci  = 1'b1; tbl[18].exp = 7'b1000001;
    tbl[23].exp = 7'b1000010;

    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < NTBL; i++) begin
      @(negedge clk);
      req_in  = tbl[i].ri;
      req_out = tbl[i].ro;
      car_in  = tbl[i].ci;
      car_out = tbl[i].co;
      count   = tbl[i].cnt;
      #1;
      check($sformatf("table[%0d]", i), outs_now(), tbl[i].exp);
    end

    // Simultaneous requests alternate: entry, exit, then entry again.
    do_reset();
    cyc(1, 1, 0, 0, 0);
    idle(1, 0);
    cyc(0, 0, 0, 0, 0); check("pair1_grant_in", {6'b0, last_got[4]}, 7'd1);
    cyc(0, 0, 1, 0, 0);
    idle(3, 0);
    cyc(0, 0, 0, 0, 0); check("pair1_grant_out", {6'b0, last_got[3]}, 7'd1);
    cyc(0, 0, 0, 1, 0);
    idle(3, 0);
    cyc(1, 1, 0, 0, 0);
    idle(1, 0);
    cyc(0, 0, 0, 0, 0); check("pair2_grant_in", {6'b0, last_got[4]}, 7'd1);
    cyc(0, 0, 1, 0, 0);
    idle(3, 0);
    cyc(0, 0, 0, 0, 0); check("pair2_grant_out", {6'b0, last_got[3]}, 7'd1);
    cyc(0, 0, 0, 1, 0);
    idle(4, 0);

    // Full lot: entry stays pending while exit is served, then granted.
    do_reset();
    cyc(1, 0, 0, 0, 7);
    idle(4, 7);
    cyc(0, 1, 0, 0, 7);
    idle(1, 7);
    cyc(0, 0, 0, 0, 7); check("full_grant_out", {5'b0, last_got[4:3]}, 7'b0000001);
    cyc(0, 0, 0, 1, 6);
    idle(3, 6);
    cyc(0, 0, 0, 0, 6); check("full_late_grant_in", {6'b0, last_got[4]}, 7'd1);
    cyc(0, 0, 1, 0, 7);
    idle(4, 7);

    // Wrong-direction pulse while open, and re-request during the grant.
    do_reset();
    cyc(1, 0, 0, 0, 0);
    idle(2, 0);
    cyc(0, 0, 0, 1, 0); check("dir_err_open", {5'b0, last_got[6], last_got[0]}, 7'b0000011);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    idle(3, 0);
    cyc(0, 0, 0, 0, 0); check("regrant_in", {6'b0, last_got[4]}, 7'd1);
    cyc(0, 0, 1, 0, 0);
    idle(4, 0);

    // Asynchronous reset mid exit grant with an entry pending.
    do_reset();
    cyc(0, 1, 0, 0, 0);
    idle(2, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0); check("pre_reset_open", {6'b0, last_got[6]}, 7'd1);
    reset = 1'b0;
    #1;
    check("async_reset_outputs", outs_now(), 7'b0000000);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    any_grant = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cyc(0, 0, 0, 0, 0);
      any_grant = any_grant | last_got[4] | last_got[3] | last_got[6];
    end
    check("no_grant_after_reset", {6'b0, any_grant}, 7'd0);

    // Randomized traffic against the model.
    do_reset();
    rc = 3'd3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) rc = (rc == 3'd7) ? rc : rc + 3'd1;
        else rc = (rc == 3'd0) ? rc : rc - 3'd1;
      end
      cyc($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, rc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
